// File: rtl/fetch_unit_pkg.sv
// Shared fetch/controller definitions.
// Widths, NOOP encoding and the opcode field of the instruction word.
package fetch_unit_pkg;

   localparam int PC_W    = 7;
   localparam int INSTR_W = 16;

   typedef logic [PC_W-1:0]    pc_t;
   typedef logic [INSTR_W-1:0] instr_t;

   localparam instr_t NOOP = 16'h0000;

   typedef enum logic [3:0] {
      OP_NOOP  = 4'h0,
      OP_LOAD  = 4'h1,
      OP_STORE = 4'h2,
      OP_ADD   = 4'h3,
      OP_SUB   = 4'h4,
      OP_JMP   = 4'h5,
      OP_JZ    = 4'h6,
      OP_HALT  = 4'hF
   } opcode_t;

   function automatic opcode_t op_of(instr_t i);
      return opcode_t'(i[INSTR_W-1:INSTR_W-4]);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port.
// Read data is valid the cycle after imem_rd.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic   imem_rd;
   pc_t    imem_addr;
   instr_t imem_rdata;

   modport master (
      output imem_rd,
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_rd,
      input  imem_addr,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter with clear, increment and wrap pulse.
// Clear wins over increment and never raises wrap.
module pc_counter
   import fetch_unit_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic up,
   output pc_t  pc,
   output logic wrap
);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc   <= '0;
         wrap <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (clr) begin
            pc <= '0;
         end else if (up) begin
            pc   <= pc + 1'b1;
            wrap <= (pc == '1);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC plus a three-state IDLE/READ/CAPTURE fetch FSM.
// PC_clr mid-fetch aborts; the in-flight read data is dropped.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          PC_clr,
   input  logic          PC_up,
   input  logic          IR_ld,
   fetch_unit_if.master  imem,
   output instr_t        instruction,
   output pc_t           pc,
   output logic          ir_valid,
   output logic          fetch_busy,
   output logic          pc_wrap
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CAPTURE
   } state_t;

   state_t state;

   pc_counter u_pc (
      .clk   (clk),
      .reset (reset),
      .clr   (PC_clr),
      .up    (PC_up),
      .pc    (pc),
      .wrap  (pc_wrap)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         imem.imem_rd   <= 1'b0;
         imem.imem_addr <= '0;
         instruction    <= NOOP;
         ir_valid       <= 1'b0;
         fetch_busy     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (IR_ld) begin
                  state          <= READ;
                  imem.imem_addr <= pc;
                  imem.imem_rd   <= 1'b1;
                  ir_valid       <= 1'b0;
                  fetch_busy     <= 1'b1;
               end
            end
            READ: begin
               imem.imem_rd <= 1'b0;
               if (PC_clr) begin
                  state      <= IDLE;
                  ir_valid   <= 1'b0;
                  fetch_busy <= 1'b0;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               state      <= IDLE;
               fetch_busy <= 1'b0;
               // An abort here keeps the old instruction word
               if (PC_clr) begin
                  ir_valid <= 1'b0;
               end else begin
                  instruction <= imem.imem_rdata;
                  ir_valid    <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               imem.imem_rd <= 1'b0;
               fetch_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic.
// Expected values come from a cycle-level behavioural model of pc and fetch phase.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset, PC_clr, PC_up, IR_ld;
   logic [15:0] instruction;
   logic [6:0]  pc;
   logic        ir_valid, fetch_busy, pc_wrap;

   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit u_dut (
      .clk         (clk),
      .reset       (reset),
      .PC_clr      (PC_clr),
      .PC_up       (PC_up),
      .IR_ld       (IR_ld),
      .imem        (bus.master),
      .instruction (instruction),
      .pc          (pc),
      .ir_valid    (ir_valid),
      .fetch_busy  (fetch_busy),
      .pc_wrap     (pc_wrap)
   );

   int tests = 0;
   int fails = 0;

   // model: phase 0 = no fetch, 1 = read cycle, 2 = data cycle
   int          m_pc = 0;
   bit          m_wrap = 0;
   int          m_phase = 0;
   int          m_addr = 0;
   logic [15:0] m_instr = 16'h0000;
   bit          m_valid = 0;
   logic [15:0] mem [128];
   logic [15:0] rdata_now;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit c, input bit u, input bit l);
      int old_pc;
      reset  = r;
      PC_clr = c;
      PC_up  = u;
      IR_ld  = l;
      rdata_now = (m_phase == 2) ? mem[m_addr] : 16'($urandom);
      bus.imem_rdata = rdata_now;
      @(posedge clk);
      if (r) begin
         m_pc = 0; m_wrap = 0; m_phase = 0;
         m_addr = 0; m_instr = 16'h0000; m_valid = 0;
      end else begin
         old_pc = m_pc;
         m_wrap = !c && u && (m_pc == 127);
         if (c) m_pc = 0;
         else if (u) m_pc = (m_pc + 1) % 128;
         case (m_phase)
            0: if (l) begin
               m_phase = 1; m_addr = old_pc; m_valid = 0;
            end
            1: m_phase = c ? 0 : 2;
            default: begin
               if (!c) begin
                  m_instr = rdata_now; m_valid = 1;
               end
               m_phase = 0;
            end
         endcase
      end
      #1;
      chk("pc", 16'(pc), 16'(m_pc));
      chk("pc_wrap", 16'(pc_wrap), 16'(m_wrap));
      chk("imem_rd", 16'(bus.imem_rd), 16'(m_phase == 1));
      chk("fetch_busy", 16'(fetch_busy), 16'(m_phase != 0));
      chk("imem_addr", 16'(bus.imem_addr), 16'(m_addr));
      chk("instruction", instruction, m_instr);
      chk("ir_valid", 16'(ir_valid), 16'(m_valid));
   endtask

   initial begin
      int wraps;
      int rds;
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
      reset = 1'b1; PC_clr = 1'b0; PC_up = 1'b0; IR_ld = 1'b0;
      bus.imem_rdata = 16'h0000;

      // reset values
      step(1, 0, 1, 1);
      step(1, 0, 0, 0);
      chk("rst_pc", 16'(pc), 16'h0);
      chk("rst_instr", instruction, 16'h0000);
      chk("rst_valid", 16'(ir_valid), 16'h0);
      chk("rst_rd", 16'(bus.imem_rd), 16'h0);

      // basic fetch latency
      mem[0] = 16'h2123;
      step(0, 0, 0, 1);
      chk("f_rd", 16'(bus.imem_rd), 16'h1);
      chk("f_addr", 16'(bus.imem_addr), 16'h0);
      step(0, 0, 0, 0);
      chk("f_rd_one", 16'(bus.imem_rd), 16'h0);
      step(0, 0, 0, 0);
      chk("f_instr", instruction, 16'h2123);
      chk("f_valid", 16'(ir_valid), 16'h1);

      // full PC wrap
      step(1, 0, 0, 0);
      wraps = 0;
      for (int i = 0; i < 128; i++) begin
         step(0, 0, 1, 0);
         if (pc_wrap) wraps++;
      end
      chk("wrap_pc", 16'(pc), 16'h0);
      chk("wrap_count", 16'(wraps), 16'h1);
      chk("wrap_last", 16'(pc_wrap), 16'h1);
      step(0, 0, 0, 0);
      chk("wrap_drop", 16'(pc_wrap), 16'h0);

      // clr beats up
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
      chk("pc5", 16'(pc), 16'h5);
      step(0, 1, 1, 0);
      chk("clr_pc", 16'(pc), 16'h0);
      chk("clr_wrap", 16'(pc_wrap), 16'h0);

      // held IR_ld
      step(1, 0, 0, 0);
      rds = 0;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1);
         if (bus.imem_rd) rds++;
      end
      chk("hold_rds", 16'(rds), 16'h1);
      step(0, 0, 0, 1);
      chk("hold_second", 16'(bus.imem_rd), 16'h1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // PC_up during READ
      step(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      chk("upr_addr", 16'(bus.imem_addr), 16'h9);
      step(0, 0, 1, 0);
      chk("upr_addr2", 16'(bus.imem_addr), 16'h9);
      chk("upr_pc", 16'(pc), 16'hA);
      step(0, 0, 0, 0);
      chk("upr_instr", instruction, mem[9]);

      // abort in READ, reset in CAPTURE
      step(1, 0, 0, 0);
      mem[3] = 16'h3456;
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("ab_pre", instruction, 16'h3456);
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      chk("ab_instr", instruction, 16'h3456);
      chk("ab_valid", 16'(ir_valid), 16'h0);
      chk("ab_busy", 16'(fetch_busy), 16'h0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(1, 0, 1, 1);
      chk("rc_instr", instruction, 16'h0000);
      chk("rc_busy", 16'(fetch_busy), 16'h0);
      chk("rc_pc", 16'(pc), 16'h0);

      // random traffic
      for (int i = 0; i < 3000; i++)
         step($urandom % 60 == 0, $urandom % 12 == 0,
              $urandom % 3 == 0, $urandom % 3 == 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
